regfile8x16: RTL and testbench
==============================

// Module: regfile8x16
// PURPOSE
//   Eight-entry x 16-bit general-purpose register file for the datapath.
//   One synchronous write port and two independent combinational read ports (A, B).
//   Built from per-bit load-enable flops (dfrl-style), a 1-of-8 write decoder
//   (demux8-style) and per-bit 8:1 read multiplexers (mux8-style).
// PARAMETERS
//   DATA_W  16  width of each register and of d_in/d_out_a/d_out_b
//   ADDR_W  3   address width; register count = 2**ADDR_W (8)
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   reset      in   1       one clock; reset is asynchronous and active-low
//   wr         in   1       write enable
//   rd_addr_a  in   ADDR_W  read port A register select
//   rd_addr_b  in   ADDR_W  read port B register select
//   wr_addr    in   ADDR_W  write register select
//   d_in       in   DATA_W  write data
//   d_out_a    out  DATA_W  contents of register rd_addr_a
//   d_out_b    out  DATA_W  contents of register rd_addr_b
// BEHAVIOUR
//   - Reset: reset=0 clears all 8 registers to 16'h0000 immediately, regardless of clk/wr.
//     Reset wins over a simultaneous write. While reset=0 no write takes effect.
//   - Write: on rising clk with reset=1 and wr=1, register[wr_addr] <= d_in.
//     The other 7 registers hold. Exactly one register is loaded per edge.
//   - wr=0: no register changes, whatever the values of wr_addr/d_in (X/unknown
//     included). The decoder gates every load line with wr.
//   - Read: d_out_a = register[rd_addr_a], d_out_b = register[rd_addr_b].
//     Reads are purely combinational, with zero-cycle latency from address change.
//   - Both read ports may select the same register, or the write target, at the same time.
//   - Read-during-write: a read port shows the old contents until the write edge.
//     It shows the new value right after that edge. There is no write-through bypass.
//   - Write latency: 1 clk edge. Data is visible on the read ports right after the capturing edge.
//   - No register is hardwired. R0 is fully writable.
//   - No handshake, no state machine, no arithmetic.
//     Address decode covers all 8 codes, so there are no out-of-range cases.
//   - Write-select bit order: wr_addr[2] is MSB. Load line k is active iff wr=1 and wr_addr==k.
//   - Read-select bit order: rd_addr[2] is MSB. Select code k returns register k.
// TESTING
//   1. Assert reset=0 mid-run after writes to R3/R7.
//      -> All reads return 16'h0000 asynchronously; a write on the same edge is discarded.
//   2. Release reset; wr=1, wr_addr=3, d_in=16'hcdef; clk edge; rd_addr_a=rd_addr_b=3
//      -> d_out_a=d_out_b=16'hcdef.
//   3. wr=0, wr_addr=4, d_in=16'hadef; clk edge; rd_addr_a=4
//      -> 16'h0000 (no write); R3 still 16'hcdef.
//   4. wr=1, wr_addr=5, d_in=16'h4567; rd_addr_a=3, rd_addr_b=7
//      -> cdef/0000. Next, wr_addr=0, d_in=16'hba98; rd_addr_a=1, rd_addr_b=5
//      -> 0000/4567. Then read R0 -> 16'hba98.
//   5. wr=0 with wr_addr/d_in = X for several edges
//      -> R0=ba98, R3=cdef, R5=4567 unchanged on both ports.
//   6. wr=1, wr_addr=7, d_in=16'hffff with rd_addr_b=7
//      -> d_out_b is 0000 before the edge and 16'hffff after it (no bypass).

Source files
------------

// File: rtl/regfile8x16.sv
// Eight-entry register file: one synchronous write port, two combinational read ports.
// Storage is cleared asynchronously by an active-low reset; there is no write-through bypass.
module regfile8x16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0]             load;
    logic [NREGS-1:0][DATA_W-1:0] regs_all;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            // wr gates every load line, so an unknown wr_addr cannot disturb storage.
            assign load[gi] = wr && (wr_addr == ADDR_W'(gi));

            always_comb begin
                reg_d = reg_q;
                if (load[gi]) begin
                    reg_d = d_in;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_all[gi] = reg_q;
        end
    endgenerate

    assign d_out_a = regs_all[rd_addr_a];
    assign d_out_b = regs_all[rd_addr_b];

endmodule

// File: tb/tb_regfile8x16.sv
// Self-checking bench for regfile8x16: directed steps followed by random traffic
// compared against an array model of the eight registers.
module tb_regfile8x16;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int tests_run;
    int tests_failed;
    logic [15:0] model [8];

    regfile8x16 dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [2:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
        check($sformatf("%s port_a R%0d", tag, a), d_out_a, model[a]);
        check($sformatf("%s port_b R%0d", tag, b), d_out_b, model[b]);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            read_check(tag, 3'(i), 3'(7 - i));
        end
    endtask

    // One rising edge; the model applies whatever write the inputs request at that edge.
    task automatic tick();
        logic        do_wr;
        logic [2:0]  a;
        logic [15:0] d;
        do_wr = wr && reset;
        a     = wr_addr;
        d     = d_in;
        @(posedge clk);
        #1;
        if (do_wr) model[a] = d;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        wr      = 1'b1;
        wr_addr = a;
        d_in    = d;
        tick();
        wr      = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_model();
        reset     = 1'b0;
        wr        = 1'b0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'h0000;

        // Power-on reset state.
        @(posedge clk);
        #1;
        check_all("reset_state");
        reset = 1'b1;

        // Mid-run async reset after writes to R3/R7, with a write pending on the same edge.
        write_reg(3'd3, 16'h1234);
        write_reg(3'd7, 16'h7777);
        read_check("pre_reset", 3'd3, 3'd7);
        check("pre_reset_r3_const", d_out_a, 16'h1234);
        wr      = 1'b1;
        wr_addr = 3'd3;
        d_in    = 16'h5555;
        reset   = 1'b0;
        #1;
        clear_model();
        read_check("async_reset", 3'd3, 3'd7);
        tick();
        read_check("reset_beats_write", 3'd3, 3'd7);
        wr    = 1'b0;
        reset = 1'b1;
        #1;

        // Write R3, read on both ports.
        write_reg(3'd3, 16'hcdef);
        read_check("wr_r3", 3'd3, 3'd3);
        check("wr_r3_const", d_out_a, 16'hcdef);

        // wr=0 must not load.
        wr_addr = 3'd4;
        d_in    = 16'hadef;
        tick();
        read_check("no_wr_r4", 3'd4, 3'd3);
        check("no_wr_r4_const", d_out_a, 16'h0000);

        write_reg(3'd5, 16'h4567);
        read_check("after_r5", 3'd3, 3'd7);
        write_reg(3'd0, 16'hba98);
        read_check("after_r0", 3'd1, 3'd5);
        read_check("r0_writable", 3'd0, 3'd0);
        check("r0_const", d_out_a, 16'hba98);

        // Unknown address/data with wr=0 for several edges.
        wr_addr = 3'bxxx;
        d_in    = 16'hxxxx;
        repeat (4) tick();
        wr_addr = 3'd0;
        d_in    = 16'h0000;
        check_all("x_inputs_no_wr");

        // No bypass: old value before the edge, new value after.
        wr        = 1'b1;
        wr_addr   = 3'd7;
        d_in      = 16'hffff;
        rd_addr_b = 3'd7;
        #1;
        check("no_bypass_before", d_out_b, 16'h0000);
        tick();
        wr = 1'b0;
        #1;
        check("no_bypass_after", d_out_b, 16'hffff);

        // Random traffic, including occasional mid-cycle resets.
        for (int n = 0; n < 300; n++) begin
            wr        = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            d_in      = 16'($urandom);
            read_check("rand_pre", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
            read_check("rand_post", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1;
                clear_model();
                read_check("rand_reset", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                reset = 1'b1;
            end
        end
        wr = 1'b0;
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
